// File: rtl/pipe_stage_ctrl.sv
// rtl/pipe_stage_ctrl.sv - multi-stage pipeline valid/payload control with stall bubbles, flush and event counters
//
// Purpose: STAGES-deep register pipeline. Stage 0 is the youngest.
// Inside a stall, stages below HOLD_STAGE hold, HOLD_STAGE takes a bubble and older stages keep draining.
// Inside a flush, the FLUSH_STAGES youngest stages are cleared and older stages keep draining.
// Flush wins over stall. enable=0 freezes everything, including the counters.
//
// Ports:
//   clk, rst        - rising-edge clock, synchronous active-high reset
//   enable          - global advance; 0 freezes all state
//   in_valid/in_data- upstream entry
//   stall, flush    - hazard hold / redirect requests
//   accept          - upstream entry consumed on this edge (combinational)
//   stage_valid     - per-stage valid, bit 0 youngest
//   stage_data      - per-stage payload, stage k at [k*DATA_W +: DATA_W]
//   out_valid/out_data - oldest stage (registered)
//   stall_cnt, flush_cnt - saturating event counters
module pipe_stage_ctrl #(
    parameter int DATA_W       = 64,
    parameter int STAGES       = 4,
    parameter int HOLD_STAGE   = 1,
    parameter int FLUSH_STAGES = 2,
    parameter int CNT_W        = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic                     in_valid,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     stall,
    input  logic                     flush,
    output logic                     accept,
    output logic [STAGES-1:0]        stage_valid,
    output logic [STAGES*DATA_W-1:0] stage_data,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    output logic [CNT_W-1:0]         stall_cnt,
    output logic [CNT_W-1:0]         flush_cnt
);

    logic [STAGES-1:0] r_valid;
    logic [DATA_W-1:0] r_data [STAGES];
    logic [CNT_W-1:0]  r_stall_cnt;
    logic [CNT_W-1:0]  r_flush_cnt;

    // What each stage would receive on a plain advance: stage k-1, or the
    // upstream entry for stage 0.
    logic [STAGES-1:0] w_prev_valid;
    logic [DATA_W-1:0] w_prev_data [STAGES];

    logic [STAGES-1:0] w_valid_nxt;
    logic [DATA_W-1:0] w_data_nxt [STAGES];

    logic w_is_flush;
    logic w_is_stall;

    assign w_is_flush = enable & flush;
    assign w_is_stall = enable & stall & ~flush;
    assign accept     = enable & ~stall & ~flush;

    assign w_prev_valid = {r_valid[STAGES-2:0], in_valid};

    genvar g;
    generate
        for (g = 0; g < STAGES; g++) begin : g_stage
            if (g == 0) begin : g_first
                assign w_prev_data[g] = in_data;
            end else begin : g_rest
                assign w_prev_data[g] = r_data[g-1];
            end
            assign stage_data[g*DATA_W +: DATA_W] = r_data[g];
        end
    endgenerate

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            w_valid_nxt[k] = w_prev_valid[k];
            w_data_nxt[k]  = w_prev_data[k];
            if (w_is_flush) begin
                if (k < FLUSH_STAGES) begin
                    w_valid_nxt[k] = 1'b0;
                    w_data_nxt[k]  = '0;
                end
            end else if (w_is_stall) begin
                if (k < HOLD_STAGE) begin
                    w_valid_nxt[k] = r_valid[k];
                    w_data_nxt[k]  = r_data[k];
                end else if (k == HOLD_STAGE) begin
                    w_valid_nxt[k] = 1'b0;
                    w_data_nxt[k]  = '0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid     <= '0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
            for (int k = 0; k < STAGES; k++) begin
                r_data[k] <= '0;
            end
        end else if (enable) begin
            r_valid <= w_valid_nxt;
            for (int k = 0; k < STAGES; k++) begin
                r_data[k] <= w_data_nxt[k];
            end
            if (w_is_stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (w_is_flush && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    assign stage_valid = r_valid;
    assign out_valid   = r_valid[STAGES-1];
    assign out_data    = r_data[STAGES-1];
    assign stall_cnt   = r_stall_cnt;
    assign flush_cnt   = r_flush_cnt;

endmodule

// File: tb/tb_pipe_stage_ctrl.sv
// tb/tb_pipe_stage_ctrl.sv - table-driven self-checking bench for pipe_stage_ctrl
module tb_pipe_stage_ctrl;

    localparam int DATA_W       = 8;
    localparam int STAGES       = 4;
    localparam int HOLD_STAGE   = 1;
    localparam int FLUSH_STAGES = 2;
    localparam int CNT_W        = 4;

    logic                     clk;
    logic                     rst;
    logic                     enable;
    logic                     in_valid;
    logic [DATA_W-1:0]        in_data;
    logic                     stall;
    logic                     flush;
    logic                     accept;
    logic [STAGES-1:0]        stage_valid;
    logic [STAGES*DATA_W-1:0] stage_data;
    logic                     out_valid;
    logic [DATA_W-1:0]        out_data;
    logic [CNT_W-1:0]         stall_cnt;
    logic [CNT_W-1:0]         flush_cnt;

    int checks;
    int errors;

    pipe_stage_ctrl #(
        .DATA_W      (DATA_W),
        .STAGES      (STAGES),
        .HOLD_STAGE  (HOLD_STAGE),
        .FLUSH_STAGES(FLUSH_STAGES),
        .CNT_W       (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .stall      (stall),
        .flush      (flush),
        .accept     (accept),
        .stage_valid(stage_valid),
        .stage_data (stage_data),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .stall_cnt  (stall_cnt),
        .flush_cnt  (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs for one edge plus the expected state after that edge.
    // ed packs stages as {s3, s2, s1, s0}.
    typedef struct {
        logic        rst;
        logic        en;
        logic        iv;
        logic [7:0]  id;
        logic        st;
        logic        fl;
        logic        acc;
        logic [3:0]  ev;
        logic [31:0] ed;
        logic [3:0]  esc;
        logic [3:0]  efc;
        string       name;
    } vec_t;

    vec_t tab_a[$];
    vec_t tab_b[$];

    function automatic vec_t mk(logic r, logic e, logic iv, logic [7:0] id, logic st, logic fl,
                                logic acc, logic [3:0] ev, logic [31:0] ed,
                                logic [3:0] esc, logic [3:0] efc, string name);
        vec_t v;
        v.rst = r; v.en = e; v.iv = iv; v.id = id; v.st = st; v.fl = fl;
        v.acc = acc; v.ev = ev; v.ed = ed; v.esc = esc; v.efc = efc; v.name = name;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(logic r, logic e, logic iv, logic [7:0] id, logic st, logic fl);
        rst = r; enable = e; in_valid = iv; in_data = id; stall = st; flush = fl;
    endtask

    task automatic check_state(string name, logic [3:0] ev, logic [31:0] ed,
                               logic [3:0] esc, logic [3:0] efc);
        chk({name, ".stage_valid"}, 32'(stage_valid), 32'(ev));
        chk({name, ".stage_data"},  stage_data, ed);
        chk({name, ".out_valid"},   32'(out_valid), 32'(ev[3]));
        chk({name, ".out_data"},    32'(out_data), 32'(ed[31:24]));
        chk({name, ".stall_cnt"},   32'(stall_cnt), 32'(esc));
        chk({name, ".flush_cnt"},   32'(flush_cnt), 32'(efc));
    endtask

    // Drive on the falling edge, check accept before the rising edge and the
    // registered state 1 time unit after it.
    task automatic run_vec(vec_t v);
        @(negedge clk);
        drive(v.rst, v.en, v.iv, v.id, v.st, v.fl);
        #1;
        chk({v.name, ".accept"}, 32'(accept), 32'(v.acc));
        @(posedge clk);
        #1;
        check_state(v.name, v.ev, v.ed, v.esc, v.efc);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

        //                  rst en iv id     st fl acc ev       ed            esc   efc
        tab_a.push_back(mk(1, 1, 0, 8'h00, 0, 0, 1, 4'b0000, 32'h00000000, 4'd0, 4'd0, "reset"));
        tab_a.push_back(mk(0, 1, 1, 8'h11, 0, 0, 1, 4'b0001, 32'h00000011, 4'd0, 4'd0, "str1"));
        tab_a.push_back(mk(0, 1, 1, 8'h22, 0, 0, 1, 4'b0011, 32'h00001122, 4'd0, 4'd0, "str2"));
        tab_a.push_back(mk(0, 1, 1, 8'h33, 0, 0, 1, 4'b0111, 32'h00112233, 4'd0, 4'd0, "str3"));
        tab_a.push_back(mk(0, 1, 0, 8'h00, 0, 0, 1, 4'b1110, 32'h11223300, 4'd0, 4'd0, "str_out11"));
        tab_a.push_back(mk(0, 1, 0, 8'h00, 0, 0, 1, 4'b1100, 32'h22330000, 4'd0, 4'd0, "str_out22"));
        tab_a.push_back(mk(0, 1, 0, 8'h00, 0, 0, 1, 4'b1000, 32'h33000000, 4'd0, 4'd0, "str_out33"));
        tab_a.push_back(mk(0, 1, 0, 8'h00, 0, 0, 1, 4'b0000, 32'h00000000, 4'd0, 4'd0, "str_drain"));
        tab_a.push_back(mk(0, 1, 1, 8'hC3, 0, 0, 1, 4'b0001, 32'h000000C3, 4'd0, 4'd0, "fillC3"));
        tab_a.push_back(mk(0, 1, 1, 8'hB2, 0, 0, 1, 4'b0011, 32'h0000C3B2, 4'd0, 4'd0, "fillB2"));
        tab_a.push_back(mk(0, 1, 1, 8'hA1, 0, 0, 1, 4'b0111, 32'h00C3B2A1, 4'd0, 4'd0, "fillA1"));
        tab_a.push_back(mk(0, 1, 1, 8'h55, 1, 0, 0, 4'b1101, 32'hC3B200A1, 4'd1, 4'd0, "stall"));
        tab_a.push_back(mk(1, 1, 1, 8'h00, 0, 0, 1, 4'b0000, 32'h00000000, 4'd0, 4'd0, "reset2"));
        tab_a.push_back(mk(0, 1, 1, 8'hC3, 0, 0, 1, 4'b0001, 32'h000000C3, 4'd0, 4'd0, "refillC3"));
        tab_a.push_back(mk(0, 1, 1, 8'hB2, 0, 0, 1, 4'b0011, 32'h0000C3B2, 4'd0, 4'd0, "refillB2"));
        tab_a.push_back(mk(0, 1, 1, 8'hA1, 0, 0, 1, 4'b0111, 32'h00C3B2A1, 4'd0, 4'd0, "refillA1"));
        tab_a.push_back(mk(0, 1, 1, 8'h66, 1, 1, 0, 4'b1100, 32'hC3B20000, 4'd0, 4'd1, "flush_stall"));
        tab_a.push_back(mk(0, 0, 1, 8'h77, 1, 1, 0, 4'b1100, 32'hC3B20000, 4'd0, 4'd1, "en_low1"));
        tab_a.push_back(mk(0, 0, 1, 8'h77, 1, 0, 0, 4'b1100, 32'hC3B20000, 4'd0, 4'd1, "en_low2"));
        tab_a.push_back(mk(0, 0, 1, 8'h77, 1, 1, 0, 4'b1100, 32'hC3B20000, 4'd0, 4'd1, "en_low3"));
        tab_a.push_back(mk(0, 0, 1, 8'h77, 1, 0, 0, 4'b1100, 32'hC3B20000, 4'd0, 4'd1, "en_low4"));
        tab_a.push_back(mk(0, 0, 1, 8'h77, 1, 1, 0, 4'b1100, 32'hC3B20000, 4'd0, 4'd1, "en_low5"));
        tab_a.push_back(mk(0, 1, 1, 8'h99, 0, 0, 1, 4'b1001, 32'hB2000099, 4'd0, 4'd1, "adv_bubbles"));
        tab_a.push_back(mk(0, 1, 1, 8'h44, 1, 0, 0, 4'b0001, 32'h00000099, 4'd1, 4'd1, "stall_invalid"));

        tab_b.push_back(mk(0, 1, 1, 8'h01, 0, 0, 1, 4'b0011, 32'h00009901, 4'd15, 4'd1, "post_sat1"));
        tab_b.push_back(mk(0, 1, 1, 8'h02, 0, 0, 1, 4'b0111, 32'h00990102, 4'd15, 4'd1, "post_sat2"));
        tab_b.push_back(mk(1, 1, 1, 8'hFF, 1, 1, 0, 4'b0000, 32'h00000000, 4'd0, 4'd0, "rst_mid"));
        tab_b.push_back(mk(0, 1, 0, 8'h00, 0, 0, 1, 4'b0000, 32'h00000000, 4'd0, 4'd0, "after_rst"));

        foreach (tab_a[i]) run_vec(tab_a[i]);

        // Saturation: 20 further stall edges starting from stall_cnt=1.
        // Stage 0 keeps 0x99 while stage 1 takes a bubble each time.
        for (int i = 0; i < 20; i++) begin
            int exp_cnt;
            @(negedge clk);
            drive(1'b0, 1'b1, 1'b1, 8'h5A, 1'b1, 1'b0);
            @(posedge clk);
            #1;
            exp_cnt = (i + 2 > 15) ? 15 : i + 2;
            chk($sformatf("sat%0d.stall_cnt", i), 32'(stall_cnt), 32'(exp_cnt));
        end
        check_state("sat_end", 4'b0001, 32'h00000099, 4'd15, 4'd1);

        foreach (tab_b[i]) run_vec(tab_b[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
